dp_ram: RTL and testbench



---
 rtl/dp_ram.sv | 53 +++++
 tb/tb_dp_ram.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dp_ram.sv
// rtl/dp_ram.sv - simple dual-port synchronous RAM, one write port, one registered read port
//
// Ports:
//   clk_in   : clock, all state updates on the rising edge
//   rst_in   : synchronous active-high reset, clears data_out and every memory word
//   data_in  : write data
//   wr_addr  : write address
//   rd_addr  : read address
//   rd_en    : read enable, data_out updates one edge later
//   wr_en    : write enable
//   data_out : registered read data, holds while rd_en is low

module dp_ram #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [data_width-1:0] data_in,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [addr_width-1:0] rd_addr,
    input  logic                  rd_en,
    input  logic                  wr_en,
    output logic [data_width-1:0] data_out
);

    localparam int depth = 2 ** addr_width;

    // Flop-based storage so that reset can clear every word.
    logic [data_width-1:0] mem [depth];

    // A read that hits the word being written in the same cycle returns the
    // incoming data (write-first) rather than the stale contents.
    logic same_addr_hit;
    assign same_addr_hit = wr_en && (wr_addr == rd_addr);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= data_in;
            end
            if (rd_en) begin
                data_out <= same_addr_hit ? data_in : mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_dp_ram.sv
// tb/tb_dp_ram.sv - self-checking bench for dp_ram with directed and randomized stimulus

module tb_dp_ram;

    localparam int aw = 8;
    localparam int dw = 32;
    localparam int words = 256;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [dw-1:0] data_in = '0;
    logic [aw-1:0] wr_addr = '0;
    logic [aw-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [dw-1:0] data_out;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of words plus the last value read out.
    logic [dw-1:0] ref_mem [words];
    logic [dw-1:0] ref_out;

    dp_ram #(.addr_width(aw), .data_width(dw)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (data_in),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .data_out (data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [dw-1:0] got, input logic [dw-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs, let the edge happen, update the model with
    // the behavioural rules, and leave time 1 unit after the edge for sampling.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [aw-1:0] wa, input logic [aw-1:0] ra,
                        input logic [dw-1:0] d);
        logic [dw-1:0] old_word;
        rst_in  = rst;
        wr_en   = we;
        rd_en   = re;
        wr_addr = wa;
        rd_addr = ra;
        data_in = d;
        @(posedge clk_in);
        if (rst) begin
            for (int i = 0; i < words; i++) ref_mem[i] = '0;
            ref_out = '0;
        end else begin
            old_word = ref_mem[ra];
            if (we) ref_mem[wa] = d;
            if (re) ref_out = (we && wa == ra) ? d : old_word;
        end
        #1;
    endtask

    initial begin
        // 1. reset, then read a few addresses
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
        check("reset_out", data_out, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0);
        check("reset_rd0", data_out, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd47, 32'd0);
        check("reset_rd47", data_out, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd255, 32'd0);
        check("reset_rd255", data_out, 32'd0);

        // 2. basic write then read, then hold with rd_en low
        step(1'b0, 1'b1, 1'b0, 8'd47, 8'd0, 32'd225);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd47, 32'd0);
        check("basic_rd47", data_out, 32'd225);
        step(1'b0, 1'b0, 1'b0, 8'd3, 8'd9, 32'd5);
        check("hold_rd_en0", data_out, 32'd225);

        // 3. same-address collision is write-first
        step(1'b0, 1'b1, 1'b1, 8'd10, 8'd10, 32'hDEADBEEF);
        check("collide_same_edge", data_out, 32'hDEADBEEF);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd10, 32'd0);
        check("collide_reread", data_out, 32'hDEADBEEF);

        // 4. different-address concurrency returns old contents
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd0, 32'd111);
        step(1'b0, 1'b1, 1'b1, 8'd6, 8'd5, 32'd222);
        check("concurrent_rd5", data_out, 32'd111);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd6, 32'd0);
        check("concurrent_rd6", data_out, 32'd222);

        // 5. address boundaries and full data width
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'hFFFFFFFF);
        step(1'b0, 1'b1, 1'b0, 8'd255, 8'd0, 32'h80000001);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0);
        check("bound_rd0", data_out, 32'hFFFFFFFF);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd255, 32'd0);
        check("bound_rd255", data_out, 32'h80000001);

        // 6. reset mid-operation discards the write and the read
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd47, 32'd0);
        check("pre_reset_rd47", data_out, 32'd225);
        step(1'b1, 1'b1, 1'b1, 8'd47, 8'd47, 32'd999);
        check("midreset_out", data_out, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd47, 32'd0);
        check("midreset_rd47", data_out, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd10, 32'd0);
        check("midreset_rd10", data_out, 32'd0);

        // Randomized traffic; a small address window makes collisions common,
        // with occasional wide addresses and rare resets.
        for (int n = 0; n < 600; n++) begin
            logic          r_rst, r_we, r_re;
            logic [aw-1:0] r_wa, r_ra;
            logic [dw-1:0] r_d;
            r_rst = ($urandom_range(0, 63) == 0);
            r_we  = $urandom_range(0, 1);
            r_re  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                r_wa = aw'($urandom_range(0, words - 1));
                r_ra = aw'($urandom_range(0, words - 1));
            end else begin
                r_wa = aw'($urandom_range(0, 7));
                r_ra = ($urandom_range(0, 3) == 0) ? r_wa : aw'($urandom_range(0, 7));
            end
            r_d = $urandom;
            step(r_rst, r_we, r_re, r_wa, r_ra, r_d);
            check("random", data_out, ref_out);
        end

        // Final sweep of the whole array against the model.
        for (int a = 0; a < words; a++) begin
            step(1'b0, 1'b0, 1'b1, 8'd0, aw'(a), 32'd0);
            check("sweep", data_out, ref_mem[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
